// File: rtl/uart_rx_hs.sv
// uart_rx_hs: 8-bit UART receiver with a fractional baud-tick generator, start-bit validation,
// framing/overrun detection and a valid/ready holding register. Define UART_RX_PARITY_EN for even parity.
module uart_rx_hs #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam longint    IncFull = (longint'(BAUD) * OVERSAMPLE * 65536 + CLK_FREQ / 2) / CLK_FREQ;
    localparam logic [16:0] Inc     = 17'(IncFull);
    localparam logic [3:0]  CntHalf = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  CntFull = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } stateT;

    logic [16:0] acc;
    logic        tick;
    logic        rxMeta;
    logic        rxdS;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitIdxNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic        deliver;
    logic        frameErrNext;
    logic        parityBad;
    logic        parityBadNext;
    logic        parityErrNext;

    // Fractional accumulator: the carry out of bit 15 is the oversample tick.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= {1'b0, acc[15:0]} + Inc;
    end

    assign tick = acc[16];

    // Idle-high reset value keeps a reset release from looking like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxdS   <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxdS   <= rxMeta;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        bitIdxNext    = bitIdx;
        shiftNext     = shiftReg;
        deliver       = 1'b0;
        frameErrNext  = 1'b0;
        parityErrNext = 1'b0;
        parityBadNext = parityBad;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxdS) begin
                        stateNext = START;
                        cntNext   = 4'd0;
                    end
                end
                START: begin
                    if (cnt == CntHalf) begin
                        cntNext    = 4'd0;
                        bitIdxNext = 3'd0;
                        stateNext  = rxdS ? IDLE : DATA;
                    end else begin
                        cntNext = cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt == CntFull) begin
                        cntNext    = 4'd0;
                        shiftNext  = {rxdS, shiftReg[7:1]};
                        bitIdxNext = bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            stateNext = PARITY;
`else
                            stateNext = STOP;
`endif
                        end
                    end else begin
                        cntNext = cnt + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CntFull) begin
                        cntNext       = 4'd0;
                        parityBadNext = ^{shiftReg, rxdS};
                        stateNext     = STOP;
                    end else begin
                        cntNext = cnt + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CntFull) begin
                        cntNext       = 4'd0;
                        frameErrNext  = !rxdS;
                        parityErrNext = parityBad;
                        deliver       = rxdS && !parityBad;
                        stateNext     = rxdS ? IDLE : WAIT_HIGH;
                    end else begin
                        cntNext = cnt + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxdS) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bitIdx    <= 3'd0;
            shiftReg  <= 8'h00;
            parityBad <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            bitIdx    <= bitIdxNext;
            shiftReg  <= shiftNext;
            parityBad <= parityBadNext;
            frame_err <= frameErrNext;
            overrun   <= 1'b0;
            // A delivery on the same clk as a read replaces the byte without an overrun.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shiftReg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= parityErrNext;
    end
`else
    assign parity_err = 1'b0;
    logic unusedParity;
    assign unusedParity = parityErrNext;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_hs.sv
// Directed bench for uart_rx_hs: 32 clk per bit, frames driven LSB first, pulses counted on negedge.
`timescale 1ns/1ps
module tb_uart_rx_hs;

    localparam int BitClk = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    always #5 clk = ~clk;

    uart_rx_hs #(.CLK_FREQ(3200000), .BAUD(100000), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    int compared = 0;
    int mismatched = 0;

    // Running event counters; the stimulus block only reads them and diffs against marks.
    int         validCycles = 0;
    int         acceptCnt = 0;
    int         frameCnt = 0;
    int         overrunCnt = 0;
    int         parityCnt = 0;
    logic [7:0] acceptData = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) validCycles++;
        if (rx_valid && rx_ready) begin
            acceptCnt++;
            acceptData = rx_data;
        end
        if (frame_err)  frameCnt++;
        if (overrun)    overrunCnt++;
        if (parity_err) parityCnt++;
    end

    int mValid, mAccept, mFrame, mOverrun, mParity;

    task automatic mark();
        mValid   = validCycles;
        mAccept  = acceptCnt;
        mFrame   = frameCnt;
        mOverrun = overrunCnt;
        mParity  = parityCnt;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sendBit(input logic b);
        rxd = b;
        waitClk(BitClk);
    endtask

    task automatic sendBody(input logic [7:0] data);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
    endtask

    task automatic sendFrame(input logic [7:0] data);
        sendBody(data);
`ifdef UART_RX_PARITY_EN
        sendBit(^data);
`endif
        sendBit(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] badByte;
        badByte = 8'hA3;

        // Reset values
        waitClk(3);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_parity_err", parity_err, 0);
        reset = 1'b0;
        waitClk(4);

        // Clean byte with consumer ready
        rx_ready = 1'b1;
        mark();
        sendFrame(8'h55);
        waitClk(16);
        check("b55_data", acceptData, 8'h55);
        check("b55_accepts", acceptCnt - mAccept, 1);
        check("b55_valid_cycles", validCycles - mValid, 1);
        check("b55_frame_err", frameCnt - mFrame, 0);
        check("b55_overrun", overrunCnt - mOverrun, 0);
        check("b55_busy", busy, 0);

        // Short low glitch must be rejected at the start-bit centre
        mark();
        rxd = 1'b0;
        waitClk(8);
        check("glitch_busy_set", busy, 1);
        rxd = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            waitClk(1);
            n++;
        end
        check("glitch_busy_clear", busy, 0);
        waitClk(64);
        check("glitch_valid", validCycles - mValid, 0);
        check("glitch_frame_err", frameCnt - mFrame, 0);

        // Stop bit low followed by a long break
        mark();
        sendBody(badByte);
`ifdef UART_RX_PARITY_EN
        sendBit(^badByte);
`endif
        rxd = 1'b0;
        waitClk(5 * BitClk);
        rxd = 1'b1;
        waitClk(64);
        check("break_frame_err", frameCnt - mFrame, 1);
        check("break_valid", validCycles - mValid, 0);
        check("break_busy", busy, 0);
        mark();
        sendFrame(8'h0F);
        waitClk(16);
        check("b0f_data", acceptData, 8'h0F);
        check("b0f_accepts", acceptCnt - mAccept, 1);
        check("b0f_frame_err", frameCnt - mFrame, 0);

        // Overrun: holding register full, consumer stalled
        rx_ready = 1'b0;
        mark();
        sendFrame(8'h11);
        waitClk(32);
        sendFrame(8'h22);
        waitClk(16);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_pulses", overrunCnt - mOverrun, 1);
        check("ovr_accepts", acceptCnt - mAccept, 0);
        rx_ready = 1'b1;
        waitClk(1);
        check("ovr_valid_drop", rx_valid, 0);
        check("ovr_accept_data", acceptData, 8'h11);
        check("ovr_accepts_after", acceptCnt - mAccept, 1);

        // Reset in the middle of 0x3C (after bit 3)
        mark();
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        check("rst_mid_busy", busy, 1);
        reset = 1'b1;
        rxd = 1'b1;
        #1;
        check("rst_async_data", rx_data, 0);
        check("rst_async_busy", busy, 0);
        waitClk(3);
        reset = 1'b0;
        waitClk(40);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frameCnt - mFrame, 0);
        check("rst_overrun", overrunCnt - mOverrun, 0);
        check("rst_accepts", acceptCnt - mAccept, 0);
        mark();
        sendFrame(8'h3C);
        waitClk(16);
        check("b3c_data", acceptData, 8'h3C);
        check("b3c_accepts", acceptCnt - mAccept, 1);
        check("b3c_rx_data", rx_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        mark();
        sendBody(8'h07);
        sendBit(1'b1);
        sendBit(1'b1);
        waitClk(16);
        check("par_ok_data", acceptData, 8'h07);
        check("par_ok_accepts", acceptCnt - mAccept, 1);
        check("par_ok_err", parityCnt - mParity, 0);
        mark();
        sendBody(8'h07);
        sendBit(1'b0);
        sendBit(1'b1);
        waitClk(16);
        check("par_bad_err", parityCnt - mParity, 1);
        check("par_bad_accepts", acceptCnt - mAccept, 0);
        check("par_bad_frame_err", frameCnt - mFrame, 0);
`else
        check("parity_tied_low", parityCnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_hs.md
# uart_rx_hs

Reset-able UART receiver with its own fractional baud-tick generator, start-bit validation, framing-error detection and a one-entry output holding register with valid/ready handshake. It is the receive-side counterpart of the team's reset-able 8N2 transmitter, pairing with it on the same serial link, and feeds bytes into the system bus glue.

## Interface
- CLK_FREQ, 25000000, clk frequency in Hz
- BAUD, 115200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit; power of 2, 4..16
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high; clock clk
- rxd  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready
- busy  output  1  state != IDLE
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- overrun  output  1  one-clk pulse: byte completed while holding register full and not being read
- parity_err  output  1  one-clk pulse, see Configuration

## Operation
- Tick generator: 17-bit acc; each clk acc <= acc[15:0] + INC; tick = acc[16]. INC = round(BAUD*OVERSAMPLE*2^16/CLK_FREQ), elaborated constant. Free-running.
- rxd passes a 2-flop synchronizer (reset value 1) -> rxd_s. All sampling uses rxd_s on tick cycles only.
- 4-bit tick counter cnt, 3-bit bit index, 8-bit shift register (LSB first).
- IDLE: on tick with rxd_s=0 -> START, cnt=0.
- START: at cnt=OVERSAMPLE/2-1: rxd_s=1 -> IDLE (glitch rejected); else -> DATA, cnt=0.
- DATA: at cnt=OVERSAMPLE-1 shift rxd_s in, cnt=0; after 8th bit -> STOP (or PARITY).
- STOP: at cnt=OVERSAMPLE-1: rxd_s=1 -> deliver, IDLE; rxd_s=0 -> frame_err, discard, WAIT_HIGH.
- WAIT_HIGH: on tick with rxd_s=1 -> IDLE (break held low never retriggers).
- Deliver: if !rx_valid or rx_ready -> rx_data<=shift, rx_valid<=1. Else overrun pulse; new byte dropped, old byte kept.
- rx_valid clears on rx_valid&rx_ready unless a delivery occurs the same clk (then stays 1 with new data, no overrun).

## Timing
- Reset: state IDLE, acc/cnt/index/shift 0, sync flops 1, rx_data 0x00, rx_valid/busy/frame_err/overrun/parity_err 0. Takes effect immediately; mid-byte reset abandons the frame with no pulse.
- Start edge to START: 2 clk sync + up to 1 tick period.
- Bit sampled at centre: half bit after edge detection, then every OVERSAMPLE ticks.
- rx_valid/frame_err/overrun/parity_err assert 1 clk after the deciding tick edge (registered).
- Line-rate error budget: tick period error < 0.5% by INC rounding.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state inserted after DATA; one bit sampled at cnt=OVERSAMPLE-1; even parity required (XOR of 8 data bits and parity bit = 0). Mismatch -> parity_err pulse at the stop-bit decision, byte discarded, frame_err still evaluated. Undefined: no PARITY state, parity_err tied 0.

## Test plan
Bench: CLK_FREQ=3200000, BAUD=100000, OVERSAMPLE=16 (INC=32768, tick every 2 clk, bit=32 clk).
- Send 0x55, 1 stop, rx_ready=1 -> rx_data=0x55, rx_valid high exactly 1 clk, no error pulses, busy back to 0.
- Drive rxd low 8 clk then high -> no rx_valid, busy returns 0 within 20 clk.
- Send 0xA3 with stop=0, hold low 5 bit times -> single frame_err, no rx_valid; then 0x0F -> rx_data=0x0F.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; raise rx_ready -> rx_valid drops next clk.
- Assert reset after bit 3 of 0x3C, release -> all outputs 0; then full 0x3C -> received correctly.
- With UART_RX_PARITY_EN: 0x07 parity=1 -> valid 0x07; 0x07 parity=0 -> parity_err, no rx_valid.
